// File: rtl/gfx256_write_combiner.sv
// Write-combining pixel packer: merges single-pixel writes into one 32-byte line
// and emits a 256-bit masked memory write on completion, line change or flush.
module gfx256_write_combiner #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        color_depth_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    input  logic [ADDR_W-1:0] pix_addr_i,
    input  logic [31:0]       pix_color_i,
    input  logic              flush_i,
    output logic              empty_o,
    output logic              mem_cyc_o,
    output logic              mem_stb_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [31:0]       mem_sel_o,
    output logic [255:0]      mem_dat_o,
    input  logic              mem_ack_i
);
    localparam int TAG_W = ADDR_W - 5;

    typedef enum logic [1:0] {EMPTY, FILL, WRITE} state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        sel_q, sel_d;
    logic [255:0]       data_q, data_d;

    logic [4:0]         off;
    logic [TAG_W-1:0]   tag_in;
    logic [3:0]         pmask;
    logic [31:0]        cmask;
    logic [31:0]        bm;
    logic [255:0]       bm_x;
    logic [255:0]       shifted;
    logic [31:0]        sel_merged;
    logic               tag_hit;
    logic               accept;

    assign off     = pix_addr_i[4:0];
    assign tag_in  = pix_addr_i[ADDR_W-1:5];
    assign tag_hit = (tag_in == tag_q);

    always_comb begin
        pmask = 4'h1;
        cmask = 32'h0000_00FF;
        case (color_depth_i)
            2'd0: begin pmask = 4'h1; cmask = 32'h0000_00FF; end
            2'd1: begin pmask = 4'h3; cmask = 32'h0000_FFFF; end
            2'd2: begin pmask = 4'h7; cmask = 32'h00FF_FFFF; end
            default: begin pmask = 4'hF; cmask = 32'hFFFF_FFFF; end
        endcase
    end

    // Bytes shifted past byte 31 fall off the top; nothing wraps into the line.
    assign bm      = {28'b0, pmask} << off;
    assign shifted = {224'b0, pix_color_i & cmask} << {off, 3'b000};
    assign sel_merged = sel_q | bm;

    for (genvar b = 0; b < 32; b++) begin : g_lane
        assign bm_x[8*b +: 8] = {8{bm[b]}};
    end

    always_comb begin
        pix_ready_o = 1'b0;
        case (state_q)
            EMPTY:   pix_ready_o = !flush_i;
            FILL:    pix_ready_o = !flush_i && tag_hit && (sel_q != '1);
            default: pix_ready_o = 1'b0;
        endcase
    end

    assign accept = pix_valid_i && pix_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            tag_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        sel_d   = sel_q;
        data_d  = data_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    tag_d   = tag_in;
                    sel_d   = bm;
                    data_d  = shifted & bm_x;
                    state_d = (bm == '1) ? WRITE : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    data_d  = (data_q & ~bm_x) | (shifted & bm_x);
                    sel_d   = sel_merged;
                    if (sel_merged == '1) state_d = WRITE;
                end else if (flush_i || (pix_valid_i && !tag_hit)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack_i) begin
                    sel_d   = '0;
                    data_d  = '0;
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Bus outputs derive from registered state only, so they hold until ack and
    // drop the instant reset is asserted.
    always_comb begin
        mem_cyc_o = (state_q == WRITE);
        mem_stb_o = (state_q == WRITE);
        mem_we_o  = (state_q == WRITE);
        mem_adr_o = (state_q == WRITE) ? {tag_q, 5'b00000} : '0;
        mem_sel_o = (state_q == WRITE) ? sel_q : '0;
        mem_dat_o = (state_q == WRITE) ? data_q : '0;
        empty_o   = (state_q == EMPTY);
    end
endmodule

// File: tb/tb_gfx256_write_combiner.sv
// Directed bench for gfx256_write_combiner: spans, flush, stalls, overlap, line edge, reset abort.
module tb_gfx256_write_combiner;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   depth;
    logic         valid;
    logic         ready;
    logic [31:0]  addr;
    logic [31:0]  color;
    logic         flush;
    logic         empty;
    logic         cyc, stb, we;
    logic [31:0]  adr;
    logic [31:0]  sel;
    logic [255:0] dat;
    logic         ack;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gfx256_write_combiner #(.ADDR_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .color_depth_i(depth),
        .pix_valid_i(valid), .pix_ready_o(ready), .pix_addr_i(addr),
        .pix_color_i(color), .flush_i(flush), .empty_o(empty),
        .mem_cyc_o(cyc), .mem_stb_o(stb), .mem_we_o(we), .mem_adr_o(adr),
        .mem_sel_o(sel), .mem_dat_o(dat), .mem_ack_i(ack)
    );

    // Offer one pixel until accepted (bounded); returns at posedge+1 after the accept.
    task automatic send_pix(input logic [31:0] a, input logic [31:0] c,
                            input logic [1:0] d, output bit ok);
        ok = 1'b0;
        addr = a; color = c; depth = d; valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        valid = 1'b0;
    endtask

    // Raise flush for one edge; returns at posedge+1 with flush low.
    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // One-cycle ack; returns at posedge+1 just after the ack edge.
    task automatic pulse_ack();
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ack = 1'b0;
        addr = '0; color = '0; depth = 2'd0;
        #12;
        total++; if (empty !== 1'b1 || cyc !== 1'b0 || stb !== 1'b0 || we !== 1'b0)
            $display("FAIL reset_ctl empty=%b cyc=%b stb=%b we=%b want 1/0/0/0", empty, cyc, stb, we);
        else passes++;
        total++; if (adr !== 32'h0 || sel !== 32'h0 || dat !== 256'h0)
            $display("FAIL reset_bus adr=%h sel=%h dat=%h want 0", adr, sel, dat);
        else passes++;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready);
        else passes++;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_span8();
        logic [255:0] exp_dat;
        int stalls = 0;
        for (int i = 0; i < 32; i++) exp_dat[8*i +: 8] = 8'(i);
        depth = 2'd0; valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            addr = 32'h100 + 32'(i); color = 32'(i);
            @(negedge clk);
            if (!ready) stalls++;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        total++; if (stalls !== 0) $display("FAIL span_stalls got %0d want 0", stalls);
        else passes++;
        @(negedge clk);
        total++; if (stb !== 1'b1 || cyc !== 1'b1 || we !== 1'b1)
            $display("FAIL span_stb stb=%b cyc=%b we=%b want 1", stb, cyc, we);
        else passes++;
        total++; if (adr !== 32'h100 || sel !== 32'hFFFF_FFFF)
            $display("FAIL span_adr_sel adr=%h sel=%h want 00000100/ffffffff", adr, sel);
        else passes++;
        total++; if (dat !== exp_dat) $display("FAIL span_dat got %h want %h", dat, exp_dat);
        else passes++;
        @(posedge clk); #1;
        pulse_ack();
        @(negedge clk);
        total++; if (stb !== 1'b0 || empty !== 1'b1)
            $display("FAIL span_after_ack stb=%b empty=%b want 0/1", stb, empty);
        else passes++;
    endtask

    task automatic test_flush32();
        bit ok;
        send_pix(32'h204, 32'hAABB_CCDD, 2'd3, ok);
        total++; if (!ok) $display("FAIL flush_accept timeout");
        else passes++;
        pulse_flush();
        @(negedge clk);
        total++; if (stb !== 1'b1 || adr !== 32'h200 || sel !== 32'h0000_00F0)
            $display("FAIL flush_bus stb=%b adr=%h sel=%h want 1/00000200/000000f0", stb, adr, sel);
        else passes++;
        total++; if (dat !== (256'hAABB_CCDD << 32))
            $display("FAIL flush_dat got %h want %h", dat, 256'hAABB_CCDD << 32);
        else passes++;
        @(posedge clk); #1;
        pulse_ack();
        @(negedge clk);
        total++; if (empty !== 1'b1) $display("FAIL flush_empty got %b want 1", empty);
        else passes++;
    endtask

    task automatic test_stall();
        bit ok;
        bit stable = 1'b1;
        send_pix(32'h40, 32'h1234, 2'd1, ok);
        total++; if (!ok) $display("FAIL stall_first timeout");
        else passes++;
        addr = 32'h60; color = 32'h5678; depth = 2'd1; valid = 1'b1;
        @(negedge clk);
        total++; if (ready !== 1'b0) $display("FAIL stall_ready_fill got %b want 0", ready);
        else passes++;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (stb !== 1'b1 || adr !== 32'h40 || sel !== 32'h3 || dat !== 256'h1234 || ready !== 1'b0)
            $display("FAIL stall_write stb=%b adr=%h sel=%h dat=%h ready=%b want 1/40/3/1234/0",
                     stb, adr, sel, dat, ready);
        else passes++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (stb !== 1'b1 || cyc !== 1'b1 || we !== 1'b1 || adr !== 32'h40 ||
                sel !== 32'h3 || dat !== 256'h1234 || ready !== 1'b0) stable = 1'b0;
        end
        total++; if (!stable) $display("FAIL stall_hold got unstable want stable");
        else passes++;
        @(posedge clk); #1;
        pulse_ack();
        @(negedge clk);
        total++; if (stb !== 1'b0 || empty !== 1'b1 || ready !== 1'b1)
            $display("FAIL stall_m1 stb=%b empty=%b ready=%b want 0/1/1", stb, empty, ready);
        else passes++;
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        total++; if (empty !== 1'b0) $display("FAIL stall_second_accept empty=%b want 0", empty);
        else passes++;
        @(posedge clk); #1;
        pulse_flush();
        @(negedge clk);
        total++; if (stb !== 1'b1 || adr !== 32'h60 || sel !== 32'h3 || dat !== 256'h5678)
            $display("FAIL stall_second_write stb=%b adr=%h sel=%h dat=%h want 1/60/3/5678",
                     stb, adr, sel, dat);
        else passes++;
        @(posedge clk); #1;
        pulse_ack();
    endtask

    task automatic test_overwrite();
        bit ok1, ok2;
        send_pix(32'h0, 32'h1122_3344, 2'd3, ok1);
        send_pix(32'h1, 32'hFFFF_FFEE, 2'd0, ok2);
        total++; if (!(ok1 && ok2)) $display("FAIL ovr_accept ok=%b%b want 11", ok1, ok2);
        else passes++;
        pulse_flush();
        @(negedge clk);
        total++; if (stb !== 1'b1 || adr !== 32'h0 || sel !== 32'hF || dat !== 256'h1122_EE44)
            $display("FAIL ovr_write stb=%b adr=%h sel=%h dat=%h want 1/0/f/1122ee44", stb, adr, sel, dat);
        else passes++;
        @(posedge clk); #1;
        pulse_ack();
    endtask

    task automatic test_line_edge();
        bit ok;
        int extra = 0;
        send_pix(32'h1E, 32'h00A1_B2C3, 2'd2, ok);
        total++; if (!ok) $display("FAIL edge_accept timeout");
        else passes++;
        pulse_flush();
        @(negedge clk);
        total++; if (stb !== 1'b1 || adr !== 32'h0 || sel !== 32'hC000_0000 || dat !== (256'hB2C3 << 240))
            $display("FAIL edge_write stb=%b adr=%h sel=%h dat=%h want 1/0/c0000000/%h",
                     stb, adr, sel, dat, 256'hB2C3 << 240);
        else passes++;
        @(posedge clk); #1;
        pulse_ack();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (stb !== 1'b0 || empty !== 1'b1) extra++;
        end
        total++; if (extra !== 0) $display("FAIL edge_no_second got %0d busy cycles want 0", extra);
        else passes++;
    endtask

    task automatic test_reset_abort();
        bit ok;
        send_pix(32'h300, 32'h55, 2'd0, ok);
        pulse_flush();
        @(negedge clk);
        total++; if (stb !== 1'b1) $display("FAIL rabort_pre stb=%b want 1", stb);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (cyc !== 1'b0 || stb !== 1'b0 || we !== 1'b0 || adr !== 32'h0 ||
                     sel !== 32'h0 || dat !== 256'h0 || empty !== 1'b1)
            $display("FAIL rabort_async cyc=%b stb=%b we=%b adr=%h sel=%h empty=%b want 0s/empty 1",
                     cyc, stb, we, adr, sel, empty);
        else passes++;
        @(posedge clk); #1; rst_n = 1'b1;
        pulse_ack();
        @(negedge clk);
        total++; if (stb !== 1'b0 || empty !== 1'b1)
            $display("FAIL rabort_stray_ack stb=%b empty=%b want 0/1", stb, empty);
        else passes++;
        @(posedge clk); #1;
        send_pix(32'h400, 32'hCAFE_F00D, 2'd3, ok);
        pulse_flush();
        @(negedge clk);
        total++; if (!ok || stb !== 1'b1 || adr !== 32'h400 || sel !== 32'hF || dat !== 256'hCAFE_F00D)
            $display("FAIL rabort_new ok=%b stb=%b adr=%h sel=%h dat=%h want 1/1/400/f/cafef00d",
                     ok, stb, adr, sel, dat);
        else passes++;
        @(posedge clk); #1;
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_span8();
        test_flush32();
        test_stall();
        test_overwrite();
        test_line_edge();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/gfx256_write_combiner.md
# gfx256_write_combiner

Write-combining pixel packer between the GFX raster/blend pipeline and the 256-bit frame-buffer memory port. It accepts a stream of single-pixel writes (byte address, colour, colour depth) and merges them into one 32-byte line buffer with a per-byte select mask. It issues one 256-bit memory write when the line is complete, when a pixel targets a different line, or on flush. It is the write-side counterpart of the pixel extraction path, and cuts memory transactions for horizontal spans by up to 32x.

## Interface
- ADDR_W, 32: byte-address width; line address is ADDR_W-5 bits.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- color_depth_i  in  2  0=8bpp, 1=16bpp, 2=24bpp, 3=32bpp; bytes per pixel = depth+1.
- pix_valid_i  in  1  pixel write request.
- pix_ready_o  out  1  pixel accepted when valid & ready at clock edge.
- pix_addr_i  in  ADDR_W  pixel byte address; [4:0] = byte offset in line.
- pix_color_i  in  32  colour, LSB-aligned; bits above depth ignored.
- flush_i  in  1  level; while high, a pending line is written out and no pixels are accepted.
- empty_o  out  1  no line pending and no bus cycle outstanding.
- mem_cyc_o, mem_stb_o  out  1  bus cycle/strobe, both asserted together.
- mem_we_o  out  1  always 1 during a cycle, 0 otherwise.
- mem_adr_o  out  ADDR_W  line address; bits [4:0] always 0.
- mem_sel_o  out  32  byte selects; bit i = byte i = dat[8i+7:8i].
- mem_dat_o  out  256  line data.
- mem_ack_i  in  1  write acknowledge; terminates the cycle.

## Operation
- States: EMPTY, FILL, WRITE.
- Pixel byte mask: ({28'b0, (1<<(depth+1))-1} << offset), truncated to 32 bits. Shifted colour: ({224'b0, color & depthmask} << 8*offset), truncated to 256 bits. Bytes beyond byte 31 are dropped and never wrap.
- pix_ready_o is combinational:
  - In EMPTY: 1 when flush_i=0.
  - In FILL: 1 when flush_i=0, pix_addr_i[ADDR_W-1:5]==tag, and sel is not all-ones.
  - In WRITE: 0.
- EMPTY + accepted pixel:
  - tag <= addr[ADDR_W-1:5]; sel <= bytemask; data <= shifted colour, with unselected bytes 0.
  - Next state is FILL, or WRITE if the mask is already all-ones.
- EMPTY + flush_i: no action; empty_o stays 1.
- FILL + accepted pixel:
  - data <= (data & ~expand(bytemask)) | (shifted & expand(bytemask)). A later pixel overwrites overlapping bytes.
  - sel <= sel | bytemask.
  - If the new sel is all-ones, next state is WRITE.
- FILL → WRITE (pixel not accepted) when:
  - pix_valid_i=1 with a tag mismatch, or
  - flush_i=1.
- WRITE:
  - mem_cyc/stb/we assert; mem_adr_o={tag,5'b0}, mem_sel_o=sel, mem_dat_o=data.
  - All bus outputs are held stable until the mem_ack_i edge.
  - On ack: bus outputs deassert, sel and data clear to 0, next state is EMPTY.
- empty_o = (state==EMPTY).

## Timing
- Reset values: state EMPTY; tag, sel, data 0; mem_cyc_o/stb_o/we_o 0; mem_adr_o, mem_sel_o, mem_dat_o 0; empty_o 1. pix_ready_o is 1 when flush_i=0.
- Reset mid-operation: the bus cycle aborts immediately (async), buffered data is discarded, and no ack is awaited after release.
- Line completion: pixel accepted at edge N → mem_stb_o high in cycle N+1.
- Tag mismatch or flush seen in FILL at edge N → mem_stb_o high in cycle N+1.
- Ack sampled at edge M → stb low and empty_o high in cycle M+1. A stalled pixel is accepted at the earliest at edge M+1.
- Minimum throughput: 1 pixel per clock within a line. One dead cycle (EMPTY) follows each write.
- Simultaneous pix_valid_i and flush_i: flush wins and the pixel stalls.
- mem_ack_i outside WRITE is ignored.
- Address wrap: tag compare uses the full upper address; no special case at the top of memory.

## Test plan
- 8bpp, addresses 0x100..0x11F, colour = low byte of address, back-to-back:
  - All 32 pixels are accepted with no stall.
  - One write follows: adr 0x100, sel 0xFFFFFFFF, byte i = 0x00+i.
  - stb rises the cycle after the 32nd accept.
- 32bpp pixel 0xAABBCCDD at 0x204, then flush_i high:
  - Write adr 0x200, sel 0x000000F0, dat[63:32]=0xAABBCCDD, all other bits 0.
  - empty_o is 1 the cycle after ack.
- 16bpp pixel 0x1234 at 0x40, then 0x5678 at 0x60:
  - Second pixel stalls.
  - Write adr 0x40, sel 0x00000003, dat[15:0]=0x1234.
  - Ack delayed 5 cycles: all outputs stable.
  - Second pixel accepted at edge M+1, then flush → write adr 0x60, sel 0x3.
- 32bpp 0x11223344 at 0x0, then 8bpp 0xEE at 0x1, then flush:
  - sel 0x0000000F, dat[31:0]=0x1122EE44.
- 24bpp 0x00A1B2C3 at 0x1E, then flush:
  - sel 0xC0000000, byte30=0xC3, byte31=0xB2, 0xA1 dropped, no second write.
- rst_ni low while mem_stb_o=1 awaiting ack:
  - All bus outputs are 0 immediately and empty_o=1.
  - After release, an ack pulse causes no state change.
  - A new pixel is accepted normally.
